ram_cmd_arbiter: RTL and testbench

//  Sequencer/arbiter in front of the single-port command RAM (10-bit din: [9:8] opcode, [7:0] payload).
//  Two requesters issue word-level read/write transactions; block arbitrates round-robin and expands

---
 rtl/ram_cmd_arbiter_if.sv | 40 ++++
 rtl/ram_cmd_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_cmd_arbiter_if.sv
// Host/RAM-side signal bundle for ram_cmd_arbiter: two requester ports, cache control,
// status, and the command RAM port.
interface ram_cmd_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 8
) ();

  logic                 req0;
  logic                 req1;
  logic                 we0;
  logic                 we1;
  logic [ADDR_SIZE-1:0] addr0;
  logic [ADDR_SIZE-1:0] addr1;
  logic [ADDR_SIZE-1:0] wdata0;
  logic [ADDR_SIZE-1:0] wdata1;
  logic                 ack0;
  logic                 ack1;
  logic [ADDR_SIZE-1:0] rdata0;
  logic [ADDR_SIZE-1:0] rdata1;
  logic                 rd_err;
  logic                 cache_inv;
  logic                 busy;
  logic [ADDR_SIZE+1:0] ram_din;
  logic                 ram_rx_valid;
  logic [ADDR_SIZE-1:0] ram_dout;
  logic                 ram_tx_valid;

  // Environment side: requesters plus the RAM itself.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, cache_inv,
    output ram_dout, ram_tx_valid,
    input  ack0, ack1, rdata0, rdata1, rd_err, busy, ram_din, ram_rx_valid
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, cache_inv,
    input  ram_dout, ram_tx_valid,
    output ack0, ack1, rdata0, rdata1, rd_err, busy, ram_din, ram_rx_valid
  );

endinterface

// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter that expands word read/write transactions from two requesters into
// command-RAM opcode sequences, optionally skipping redundant set-address commands.
module ram_cmd_arbiter #(
  parameter int unsigned ADDR_SIZE     = 8,
  parameter bit          ADDR_CACHE_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  ram_cmd_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWdata,
    StRaddr,
    StRcmd,
    StRcap,
    StAck
  } state_e;

  state_e               state_q, state_d;
  logic                 win_q, win_d;
  logic                 ptr_q, ptr_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic                 err_q;
  logic [ADDR_SIZE-1:0] rdata0_q, rdata1_q;
  logic                 wc_vld_q, rc_vld_q;
  logic [ADDR_SIZE-1:0] wc_addr_q, rc_addr_q;

  logic                 any_req;
  logic                 sel_win;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [ADDR_SIZE-1:0] sel_wdata;
  logic                 w_hit;
  logic                 r_hit;

  // Arbitration candidate; only consumed while idle.
  assign any_req   = bus.req0 | bus.req1;
  assign sel_win   = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
  assign sel_we    = sel_win ? bus.we1    : bus.we0;
  assign sel_addr  = sel_win ? bus.addr1  : bus.addr0;
  assign sel_wdata = sel_win ? bus.wdata1 : bus.wdata0;

  // An invalidate in the same cycle forces a miss.
  assign w_hit = ADDR_CACHE_EN && !bus.cache_inv && wc_vld_q && (sel_addr == wc_addr_q);
  assign r_hit = ADDR_CACHE_EN && !bus.cache_inv && rc_vld_q && (sel_addr == rc_addr_q);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          win_d   = sel_win;
          ptr_d   = ~sel_win;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (sel_we) begin
            state_d = w_hit ? StWdata : StWaddr;
          end else begin
            state_d = r_hit ? StRcmd : StRaddr;
          end
        end
      end
      StWaddr: state_d = StWdata;
      StWdata: state_d = StAck;
      StRaddr: state_d = StRcmd;
      StRcmd:  state_d = StRcap;
      StRcap:  state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      win_q   <= 1'b0;
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Address caches track the last address command actually sent to the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc_vld_q  <= 1'b0;
      rc_vld_q  <= 1'b0;
      wc_addr_q <= '0;
      rc_addr_q <= '0;
    end else if (bus.cache_inv) begin
      wc_vld_q <= 1'b0;
      rc_vld_q <= 1'b0;
    end else begin
      if (state_q == StWaddr) begin
        wc_vld_q  <= 1'b1;
        wc_addr_q <= addr_q;
      end
      if (state_q == StRaddr) begin
        rc_vld_q  <= 1'b1;
        rc_addr_q <= addr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == StRcap) begin
      err_q <= ~bus.ram_tx_valid;
      if (win_q) begin
        rdata1_q <= bus.ram_dout;
      end else begin
        rdata0_q <= bus.ram_dout;
      end
    end
  end

  always_comb begin
    bus.ram_rx_valid = 1'b0;
    bus.ram_din      = '0;
    bus.ack0         = 1'b0;
    bus.ack1         = 1'b0;
    bus.rd_err       = 1'b0;
    unique case (state_q)
      StWaddr: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {2'b00, addr_q};
      end
      StWdata: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {2'b01, wdata_q};
      end
      StRaddr: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {2'b10, addr_q};
      end
      StRcmd: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {2'b11, {ADDR_SIZE{1'b0}}};
      end
      StAck: begin
        bus.ack0   = ~win_q;
        bus.ack1   = win_q;
        bus.rd_err = err_q & ~we_q;
      end
      default: ;
    endcase
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Self-checking bench: transaction-level model predicts every output cycle of the cached DUT;
// directed tests add literal expectations, plus a second uncached instance.
module tb_ram_cmd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   txv_force = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_cmd_arbiter_if #(.ADDR_SIZE(8)) bus ();
  ram_cmd_arbiter_if #(.ADDR_SIZE(8)) bus2 ();

  ram_cmd_arbiter #(.ADDR_SIZE(8), .ADDR_CACHE_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ram_cmd_arbiter #(.ADDR_SIZE(8), .ADDR_CACHE_EN(1'b0)) dut_nc (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- Command RAM behavioural stand-in ----------------
  logic [7:0] r_mem [256];
  logic [7:0] r_wa, r_ra, r_dout;
  initial begin
    for (int i = 0; i < 256; i++) r_mem[i] = 8'(i) ^ 8'h3C;
    r_wa = '0; r_ra = '0; r_dout = '0;
  end
  always @(posedge clk) begin
    if (bus.ram_rx_valid) begin
      case (bus.ram_din[9:8])
        2'b00: r_wa <= bus.ram_din[7:0];
        2'b01: r_mem[r_wa] <= bus.ram_din[7:0];
        2'b10: r_ra <= bus.ram_din[7:0];
        default: r_dout <= r_mem[r_ra];
      endcase
    end
  end
  assign bus.ram_dout     = r_dout;
  assign bus.ram_tx_valid = !txv_force;
  assign bus2.ram_dout     = 8'h77;
  assign bus2.ram_tx_valid = 1'b1;

  // ---------------- Transaction-level model ----------------
  // Each accepted transaction becomes a script of per-cycle expected outputs.
  typedef struct packed {
    logic       idle;
    logic       rxv;
    logic [9:0] din;
    logic       a0;
    logic       a1;
    logic       err;
    logic       upd_w;
    logic       upd_r;
    logic [7:0] ua;
    logic       mw;
    logic [7:0] ma;
    logic [7:0] md;
    logic       setrd;
    logic [7:0] rv;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  int         m_ptr;
  bit         m_wv, m_rv;
  logic [7:0] m_wa, m_ra;
  logic [7:0] m_mem [256];
  logic [7:0] exp_rd0, exp_rd1;

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t idle_e();
    exp_t e;
    e = blank();
    e.idle = 1'b1;
    return e;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h3C;
    cur = idle_e(); m_ptr = 0; m_wv = 0; m_rv = 0; m_wa = '0; m_ra = '0;
    exp_rd0 = '0; exp_rd1 = '0;
  end

  task automatic m_decide();
    int         w;
    bit         we, hit;
    logic [7:0] a, d;
    exp_t       e;
    w     = (bus.req0 && bus.req1) ? m_ptr : (bus.req1 ? 1 : 0);
    m_ptr = 1 - w;
    we    = (w == 1) ? bus.we1 : bus.we0;
    a     = (w == 1) ? bus.addr1 : bus.addr0;
    d     = (w == 1) ? bus.wdata1 : bus.wdata0;
    if (we) begin
      hit = !bus.cache_inv && m_wv && (m_wa == a);
      if (!hit) begin
        e = blank(); e.rxv = 1; e.din = {2'b00, a}; e.upd_w = 1; e.ua = a; q.push_back(e);
      end
      e = blank(); e.rxv = 1; e.din = {2'b01, d}; e.mw = 1; e.ma = a; e.md = d; q.push_back(e);
      e = blank(); e.a0 = (w == 0); e.a1 = (w == 1); q.push_back(e);
    end else begin
      hit = !bus.cache_inv && m_rv && (m_ra == a);
      if (!hit) begin
        e = blank(); e.rxv = 1; e.din = {2'b10, a}; e.upd_r = 1; e.ua = a; q.push_back(e);
      end
      e = blank(); e.rxv = 1; e.din = 10'h300; q.push_back(e);
      e = blank(); q.push_back(e);
      e = blank(); e.a0 = (w == 0); e.a1 = (w == 1); e.err = txv_force;
      e.setrd = 1; e.rv = m_mem[a]; q.push_back(e);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cur = idle_e(); m_ptr = 0; m_wv = 0; m_rv = 0;
      exp_rd0 = '0; exp_rd1 = '0;
    end else begin
      if (cur.idle) begin
        if (bus.req0 || bus.req1) begin
          m_decide();
          cur = q.pop_front();
        end
      end else begin
        if (cur.upd_w && !bus.cache_inv) begin m_wv = 1; m_wa = cur.ua; end
        if (cur.upd_r && !bus.cache_inv) begin m_rv = 1; m_ra = cur.ua; end
        if (cur.mw) m_mem[cur.ma] = cur.md;
        cur = (q.size() > 0) ? q.pop_front() : idle_e();
      end
      if (bus.cache_inv) begin m_wv = 0; m_rv = 0; end
      if (cur.setrd) begin
        if (cur.a1) exp_rd1 = cur.rv;
        else        exp_rd0 = cur.rv;
      end
    end
  end

  // Single compare process: every cycle, all outputs of the cached instance.
  always @(negedge clk) begin
    chk("ram_rx_valid", 32'(bus.ram_rx_valid), 32'(cur.rxv));
    chk("ram_din", 32'(bus.ram_din), 32'(cur.din));
    chk("ack0", 32'(bus.ack0), 32'(cur.a0));
    chk("ack1", 32'(bus.ack1), 32'(cur.a1));
    chk("rd_err", 32'(bus.rd_err), 32'(cur.err));
    chk("busy", 32'(bus.busy), 32'(!cur.idle));
    chk("rdata0", 32'(bus.rdata0), 32'(exp_rd0));
    chk("rdata1", 32'(bus.rdata1), 32'(exp_rd1));
  end

  // ---------------- Monitors for the directed literals ----------------
  logic [9:0] din_log[$];
  int         grant_log[$];
  int         ack_cnt = 0;
  bit         last_err = 0;
  int         cnt207 = 0;
  always @(negedge clk) begin
    if (bus.ram_rx_valid) din_log.push_back(bus.ram_din);
    if (bus.ack0) begin grant_log.push_back(0); ack_cnt++; last_err = bus.rd_err; end
    if (bus.ack1) begin grant_log.push_back(1); ack_cnt++; last_err = bus.rd_err; end
    if (bus2.ram_rx_valid && bus2.ram_din == 10'h207) cnt207++;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_txn(input int r, input bit we, input logic [7:0] a, input logic [7:0] d,
                        output int lat);
    int start;
    bit got;
    @(posedge clk); #1;
    if (r == 0) begin bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1; end
    else        begin bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1; end
    start = cyc;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((r == 0 && bus.ack0) || (r == 1 && bus.ack1)) got = 1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout: requester %0d, no ack within 20 cycles", r);
    end
    lat = cyc - start;
    @(posedge clk); #1;
    if (r == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  task automatic do_txn2(input logic [7:0] a, output int lat);
    int start;
    bit got;
    @(posedge clk); #1;
    bus2.we0 = 1'b0; bus2.addr0 = a; bus2.req0 = 1'b1;
    start = cyc;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus2.ack0) got = 1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout_nc: no ack within 20 cycles");
    end
    lat = cyc - start;
    @(posedge clk); #1;
    bus2.req0 = 1'b0;
  endtask

  initial begin
    int lat;
    int c0;
    bit got;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0; bus.cache_inv = 0;
    bus2.req0 = 0; bus2.req1 = 0; bus2.we0 = 0; bus2.we1 = 0;
    bus2.addr0 = '0; bus2.addr1 = '0; bus2.wdata0 = '0; bus2.wdata1 = '0; bus2.cache_inv = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: write then read-back through different requesters
    chk("reset_busy", 32'(bus.busy), 32'd0);
    din_log.delete();
    do_txn(0, 1'b1, 8'h12, 8'hA5, lat);
    chk("t1_wr_lat", 32'(lat), 32'd3);
    chk("t1_wr_cmds", 32'(din_log.size()), 32'd2);
    chk("t1_waddr", 32'(din_log[0]), 32'h012);
    chk("t1_wdata", 32'(din_log[1]), 32'h1A5);
    din_log.delete();
    do_txn(1, 1'b0, 8'h12, 8'h00, lat);
    chk("t1_rd_lat", 32'(lat), 32'd4);
    chk("t1_raddr", 32'(din_log[0]), 32'h212);
    chk("t1_rcmd", 32'(din_log[1]), 32'h300);
    chk("t1_rdata1", 32'(bus.rdata1), 32'hA5);
    chk("t1_rd_err", 32'(last_err), 32'd0);

    // 2: both requesters hammering -> strict alternation starting at r0
    do_reset();
    grant_log.delete();
    bus.we0 = 1; bus.addr0 = 8'h20; bus.wdata0 = 8'h11;
    bus.we1 = 0; bus.addr1 = 8'h20;
    bus.req0 = 1; bus.req1 = 1;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 4) got = 1;
    end
    @(posedge clk); #1;
    bus.req0 = 0; bus.req1 = 0;
    chk("t2_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
    chk("t2_rdata1", 32'(bus.rdata1), 32'h11);

    // 3: address cache hit, then invalidate
    do_reset();
    din_log.delete();
    do_txn(0, 1'b1, 8'h40, 8'h01, lat);
    chk("t3_miss_lat", 32'(lat), 32'd3);
    din_log.delete();
    do_txn(0, 1'b1, 8'h40, 8'h02, lat);
    chk("t3_hit_lat", 32'(lat), 32'd2);
    chk("t3_hit_cmds", 32'(din_log.size()), 32'd1);
    chk("t3_hit_din", 32'(din_log[0]), 32'h102);
    @(posedge clk); #1 bus.cache_inv = 1;
    @(posedge clk); #1 bus.cache_inv = 0;
    din_log.delete();
    do_txn(0, 1'b1, 8'h40, 8'h03, lat);
    chk("t3_inv_lat", 32'(lat), 32'd3);
    chk("t3_inv_waddr", 32'(din_log[0]), 32'h040);

    // 4: reset while the read command is on the bus
    do_reset();
    @(posedge clk); #1;
    bus.we0 = 0; bus.addr0 = 8'h55; bus.req0 = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.ram_rx_valid && bus.ram_din == 10'h300) got = 1;
    end
    chk("t4_reached_rcmd", 32'(got), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t4_rx_valid", 32'(bus.ram_rx_valid), 32'd0);
    chk("t4_ack0", 32'(bus.ack0), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    bus.req0 = 0;
    @(posedge clk); #1 rst = 1'b0;
    c0 = ack_cnt;
    repeat (8) @(negedge clk);
    chk("t4_no_ack", 32'(ack_cnt - c0), 32'd0);
    chk("t4_idle", 32'(bus.busy), 32'd0);

    // 5: RAM read-valid low at capture
    txv_force = 1;
    do_txn(1, 1'b0, 8'h33, 8'h00, lat);
    txv_force = 0;
    chk("t5_lat", 32'(lat), 32'd4);
    chk("t5_rd_err", 32'(last_err), 32'd1);
    chk("t5_rdata1", 32'(bus.rdata1), 32'h0F);

    // 6: uncached instance re-issues the address every time
    for (int k = 0; k < 3; k++) begin
      c0 = cnt207;
      do_txn2(8'h07, lat);
      chk($sformatf("t6_lat%0d", k), 32'(lat), 32'd4);
      chk($sformatf("t6_raddr%0d", k), 32'(cnt207 - c0), 32'd1);
    end
    chk("t6_rdata0", 32'(bus2.rdata0), 32'h77);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
